// File: rtl/screen_pkg.sv
// Shared constants and types for the screen RAM fetch path.
package screen_pkg;

  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam int          SCREEN_WORDS = 8192;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_t;

  // The screen occupies the 8K-word window whose top two address bits match SCREEN_BASE.
  function automatic logic is_screen_hit(input logic [14:0] address);
    return address[14:13] == SCREEN_BASE[14:13];
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata whenever valid is high.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = count != '0;
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = valid ? mem[rd_ptr] : '0;

  // Flush beats any push or pop in the same cycle; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/screen_fetch_arbiter.sv
// Shares the single-port screen RAM between CPU data accesses (always granted) and
// sequential video prefetch into a show-ahead FIFO drained by the pixel serializer.
module screen_fetch_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SCREEN_WORDS = screen_pkg::SCREEN_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] cpu_address,
  input  logic        cpu_write,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic [12:0] ram_address,
  output logic        ram_write,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        frame_start,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [7:0]  underrun_count
);

  import screen_pkg::*;

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [12:0] LAST_PTR = 13'(SCREEN_WORDS - 1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [12:0]   ptr;
  logic [12:0]   last_address;
  logic          inflight;
  logic          cpu_read_q;
  logic          primed;
  logic          cpu_hit;
  logic          room;
  logic          fetch_issue;
  logic          last_issue;
  logic          restart;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;

  // No grants while reset is held so the RAM sees no traffic during reset.
  assign cpu_hit     = reset && is_screen_hit(cpu_address);
  assign room        = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign fetch_issue = reset && (state == FETCH) && !cpu_hit && !frame_start && room;
  assign last_issue  = fetch_issue && (ptr == LAST_PTR);
  assign restart     = frame_start && (state == FETCH);
  assign fifo_pop    = pix_valid && pix_ready;
  assign cpu_rdata   = cpu_read_q ? ram_rdata : '0;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (frame_start) state_next = FETCH;
      FETCH:      if (!frame_start && last_issue) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // CPU owns the port on a hit; otherwise a fetch may use it, else the address bus parks.
  always_comb begin
    ram_address = last_address;
    ram_write   = 1'b0;
    ram_wdata   = '0;
    if (cpu_hit) begin
      ram_address = cpu_address[12:0];
      ram_write   = cpu_write;
      ram_wdata   = cpu_wdata;
    end else if (fetch_issue) begin
      ram_address = ptr;
    end
  end

  // Starvation only counts once the current frame has delivered its first word,
  // so the unavoidable fill latency after frame_start is not reported as underrun.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr            <= '0;
      inflight       <= 1'b0;
      cpu_read_q     <= 1'b0;
      primed         <= 1'b0;
      last_address   <= '0;
      underrun_count <= '0;
    end else begin
      inflight     <= fetch_issue;
      cpu_read_q   <= cpu_hit && !cpu_write;
      last_address <= ram_address;
      if (frame_start)      ptr <= '0;
      else if (fetch_issue) ptr <= last_issue ? '0 : ptr + 13'd1;
      if (frame_start)      primed <= 1'b0;
      else if (inflight)    primed <= 1'b1;
      if (pix_ready && !pix_valid && (state == FETCH) && primed && (underrun_count != 8'hFF))
        underrun_count <= underrun_count + 8'd1;
    end
  end

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight),
    .pop   (fifo_pop),
    .flush (restart),
    .wdata (ram_rdata),
    .rdata (pix_data),
    .valid (pix_valid),
    .count (fifo_count)
  );

endmodule
